micro_sequencer: RTL and testbench
==================================

Name: micro_sequencer

Overview:
- Microprogram sequencer for the stack-machine microarchitecture. Owns the microprogram counter (MPC), drives the 7-bit address of the combinational 23-bit control store, and computes the next address from the returned microinstruction.
- Next-address sources: NEXT_ADDR, conditional jam on latched ALU flags, or opcode dispatch.
- Also handles memory-wait stalls, instruction-boundary halt, illegal-dispatch trap, and a microcycle counter.

Parameters:
- ADDR_W, 7, control-store address width
- UWORD_W, 23, microinstruction width
- ROM_DEPTH, 92, populated control-store words; any address >= ROM_DEPTH is illegal
- FETCH_ADDR, 0, fetch microinstruction address; start and halt point
- CNT_W, 16, microcycle counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  leave IDLE and begin at FETCH_ADDR
- halt_req  in  1  stop at the next instruction boundary
- uaddr  out  ADDR_W  control-store address (= MPC)
- uinstr  in  UWORD_W  control-store data for uaddr
- alu_z  in  1  ALU zero result of the current microinstruction
- alu_n  in  1  ALU negative result of the current microinstruction
- disp_addr  in  ADDR_W  entry address from the opcode decode table
- disp_valid  in  1  opcode is legal
- mem_wait  in  1  memory not ready; freeze sequencing
- uexec  out  1  datapath must execute uinstr this cycle
- running  out  1  state is RUN
- trap  out  1  illegal next address detected; sticky
- trap_addr  out  ADDR_W  MPC at the moment the trap was taken
- ucycles  out  CNT_W  count of executed microinstructions

Behaviour:
- Microinstruction fields: [6:0] NEXT_ADDR; [8:7] SEL (2'b11 = dispatch, any other value = sequential); [9] JAMN; [10] JAMZ; [22:11] are datapath controls and are not interpreted here.
- States:
  - IDLE: MPC = FETCH_ADDR, uexec = 0.
  - RUN
  - TRAP: terminal until reset.
- Reset: rst_n sampled low at a clock edge forces, at that edge:
  - state = IDLE, MPC = 0, z_q = n_q = 0, halt_pend = 0
  - trap = 0, trap_addr = 0, ucycles = 0
  - uexec and running are therefore 0.
  - Reset overrides all other inputs, including mid-stall and in TRAP.
- IDLE → RUN on the edge where start = 1. The first executed word is FETCH_ADDR, one cycle later.
- uexec = (state == RUN) & ~mem_wait. This is combinational, with no added latency.
- An edge with uexec = 1 retires one microinstruction:
  - MPC ← next, z_q ← alu_z, n_q ← alu_n
  - ucycles += 1, wrapping modulo 2^CNT_W.
- While mem_wait = 1 in RUN:
  - MPC, flags and ucycles hold.
  - uaddr is stable, so the same word is re-presented each cycle.
- Next-address computation:
  - SEL = 11: next = disp_addr. If disp_valid = 0, the trap fires.
  - Otherwise: taken = (JAMZ & z_q) | (JAMN & n_q); next = taken ? (NEXT_ADDR | 7'h40) : NEXT_ADDR.
  - Jam uses flags latched from the previous executed microinstruction, not the live alu_z/alu_n.
  - Bit 6 is ORed, never added; there is no carry.
- Trap condition, evaluated only when uexec = 1: next >= ROM_DEPTH, or a dispatch with disp_valid = 0.
  - On trap: state ← TRAP, trap ← 1, trap_addr ← current MPC.
  - MPC, flags and ucycles do not update on the trapping edge.
- Halt:
  - halt_req = 1 in RUN sets halt_pend.
  - On an edge with uexec = 1 and next == FETCH_ADDR, with halt_pend or halt_req set: MPC ← FETCH_ADDR, state ← IDLE, halt_pend cleared.
  - The last word of the current instruction executes; fetch does not.
- Halt and trap on the same edge: trap wins.
- halt_req in IDLE or TRAP is ignored. start in RUN or TRAP is ignored.

Test Plan:
- Reset, then start = 1, with uinstr at 0 having NEXT_ADDR = 91 and SEL = 00 → uaddr = 0 one cycle after start, uaddr = 91 next cycle, ucycles = 1.
- Word with NEXT_ADDR = 12 and JAMZ = 1, previous word executed with alu_z = 1 → uaddr = 76. Repeat with alu_z = 0 → uaddr = 12. Changing live alu_z during the branch word has no effect.
- SEL = 11, disp_valid = 1, disp_addr = 27 → uaddr = 27. With disp_valid = 0 at MPC = 91 → trap = 1, trap_addr = 91, uaddr held at 91, uexec = 0 thereafter, rst_n low clears trap.
- mem_wait high for 3 cycles at MPC = 5 → uexec = 0 for 3 cycles, uaddr = 5, ucycles unchanged. Executes on the 4th cycle.
- halt_req pulsed 1 cycle at MPC = 6 in a chain 5→6→7→8→0 → words 7 and 8 execute, state becomes IDLE with uaddr = 0, running = 0.
- Word with NEXT_ADDR = 100 (>= 92) → trap. rst_n low for one cycle mid-stall → all outputs return to reset values on that edge.

Source files
------------

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// micro_sequencer : microprogram counter, next-address logic, stall/halt/trap
// Revision 1.0
// ============================================================================
module micro_sequencer #(
  parameter int ADDR_W     = 7,
  parameter int UWORD_W    = 23,
  parameter int ROM_DEPTH  = 92,
  parameter int FETCH_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               halt_req,
  output logic [ADDR_W-1:0]  uaddr,
  input  logic [UWORD_W-1:0] uinstr,
  input  logic               alu_z,
  input  logic               alu_n,
  input  logic [ADDR_W-1:0]  disp_addr,
  input  logic               disp_valid,
  input  logic               mem_wait,
  output logic               uexec,
  output logic               running,
  output logic               trap,
  output logic [ADDR_W-1:0]  trap_addr,
  output logic [CNT_W-1:0]   ucycles
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_trap = 2'd2;

  localparam logic [ADDR_W:0]   c_rom_depth = (ADDR_W+1)'(ROM_DEPTH);
  localparam logic [ADDR_W-1:0] c_fetch     = ADDR_W'(FETCH_ADDR);

  logic [1:0]        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_mpc, r_trap_addr, w_next;
  logic              r_zq, r_nq, r_halt_pend, r_trap;
  logic [CNT_W-1:0]  r_ucycles;
  logic              w_dispatch, w_taken, w_illegal, w_trap_hit, w_halt_hit;
  logic              w_uexec, w_running;
  logic              w_unused;

  // Datapath control bits pass through to the datapath untouched.
  assign w_unused = ^uinstr[UWORD_W-1:ADDR_W+4];

  always_comb begin
    w_dispatch = (uinstr[ADDR_W+1:ADDR_W] == 2'b11);
    w_taken    = (uinstr[ADDR_W+3] & r_zq) | (uinstr[ADDR_W+2] & r_nq);
    if (w_dispatch) begin
      w_next = disp_addr;
    end else begin
      // Jam ORs the top address bit in; no carry into lower bits.
      w_next = {uinstr[ADDR_W-1] | w_taken, uinstr[ADDR_W-2:0]};
    end
    w_illegal  = ({1'b0, w_next} >= c_rom_depth) | (w_dispatch & ~disp_valid);
    w_trap_hit = w_uexec & w_illegal;
    w_halt_hit = w_uexec & ~w_illegal & (w_next == c_fetch) & (r_halt_pend | halt_req);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle: if (start) w_state_nxt = c_run;
      c_run: begin
        if (w_trap_hit) begin
          w_state_nxt = c_trap;
        end else if (w_halt_hit) begin
          w_state_nxt = c_idle;
        end
      end
      c_trap:  w_state_nxt = c_trap;
      default: w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    w_running = (r_state == c_run);
    w_uexec   = w_running & ~mem_wait;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mpc       <= c_fetch;
      r_zq        <= 1'b0;
      r_nq        <= 1'b0;
      r_halt_pend <= 1'b0;
      r_trap      <= 1'b0;
      r_trap_addr <= '0;
      r_ucycles   <= '0;
    end else begin
      if (w_trap_hit) begin
        r_trap      <= 1'b1;
        r_trap_addr <= r_mpc;
      end else if (w_uexec) begin
        r_mpc     <= w_next;
        r_zq      <= alu_z;
        r_nq      <= alu_n;
        r_ucycles <= r_ucycles + CNT_W'(1);
      end
      if (w_halt_hit) begin
        r_halt_pend <= 1'b0;
      end else if (w_running & halt_req) begin
        r_halt_pend <= 1'b1;
      end
    end
  end

  assign uaddr     = r_mpc;
  assign uexec     = w_uexec;
  assign running   = w_running;
  assign trap      = r_trap;
  assign trap_addr = r_trap_addr;
  assign ucycles   = r_ucycles;

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
// tb_micro_sequencer : directed vector table plus randomized run vs. a model
// Revision 1.0
// ============================================================================
module tb_micro_sequencer;

  logic        clk;
  logic        rst_n, start, halt_req, alu_z, alu_n, disp_valid, mem_wait;
  logic [6:0]  uaddr, disp_addr, trap_addr;
  logic [22:0] uinstr;
  logic        uexec, running, trap;
  logic [15:0] ucycles;

  logic [22:0] rom [0:127];
  assign uinstr = rom[uaddr];

  micro_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .uaddr(uaddr), .uinstr(uinstr), .alu_z(alu_z), .alu_n(alu_n),
    .disp_addr(disp_addr), .disp_valid(disp_valid), .mem_wait(mem_wait),
    .uexec(uexec), .running(running), .trap(trap), .trap_addr(trap_addr),
    .ucycles(ucycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [22:0] mk(input int nxt, input int sel, input bit jamn, input bit jamz);
    logic [6:0] a;
    logic [1:0] s;
    a = 7'(nxt);
    s = 2'(sel);
    return {12'h000, jamz, jamn, s, a};
  endfunction

  typedef struct {
    bit rst_n, start, halt, z, mw, dv;
    int da;
    int e_ua, e_ux, e_run, e_tr, e_ta, e_ucy;
  } vec_t;

  function automatic vec_t v(input bit r, s, h, z, mw, dv, input int da,
                             input int ua, ux, run, tr, ta, ucy);
    vec_t t;
    t.rst_n = r; t.start = s; t.halt = h; t.z = z; t.mw = mw; t.dv = dv; t.da = da;
    t.e_ua = ua; t.e_ux = ux; t.e_run = run; t.e_tr = tr; t.e_ta = ta; t.e_ucy = ucy;
    return t;
  endfunction

  // Reference model state, expressed in terms of the specified behaviour.
  typedef enum {M_IDLE, M_RUN, M_TRAP} mstate_t;
  mstate_t m_st;
  int m_mpc, m_taddr, m_ucy;
  bit m_z, m_n, m_pend, m_trap;

  task automatic model_reset();
    m_st = M_IDLE; m_mpc = 0; m_z = 0; m_n = 0; m_pend = 0;
    m_trap = 0; m_taddr = 0; m_ucy = 0;
  endtask

  task automatic model_step();
    int sel, nxt;
    bit bad;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_st)
      M_IDLE: if (start) m_st = M_RUN;
      M_RUN: begin
        if (!mem_wait) begin
          sel = int'(rom[m_mpc][8:7]);
          if (sel == 3) begin
            nxt = int'(disp_addr);
            bad = !disp_valid;
          end else begin
            nxt = int'(rom[m_mpc][6:0]);
            if ((rom[m_mpc][10] && m_z) || (rom[m_mpc][9] && m_n)) nxt = nxt | 64;
            bad = 0;
          end
          if (nxt >= 92) bad = 1;
          if (bad) begin
            m_st = M_TRAP; m_trap = 1; m_taddr = m_mpc;
          end else begin
            if (nxt == 0 && (m_pend || halt_req)) begin
              m_st = M_IDLE; m_pend = 0;
            end else if (halt_req) begin
              m_pend = 1;
            end
            m_mpc = nxt; m_z = alu_z; m_n = alu_n;
            m_ucy = (m_ucy + 1) % 65536;
          end
        end else if (halt_req) begin
          m_pend = 1;
        end
      end
      default: ;
    endcase
  endtask

  vec_t tbl[$];

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 23'h0;
    rom[0]  = mk(91, 0, 0, 0);
    rom[91] = mk(0, 3, 0, 0);
    rom[27] = mk(30, 0, 0, 0);
    rom[30] = mk(12, 0, 0, 1);
    rom[76] = mk(5, 0, 0, 0);
    rom[5]  = mk(6, 0, 0, 0);
    rom[6]  = mk(7, 0, 0, 0);
    rom[7]  = mk(8, 0, 0, 0);
    rom[8]  = mk(0, 0, 0, 0);
    rom[12] = mk(100, 0, 0, 0);

    //            rst st hl z mw dv da   ua  ux run tr ta ucy
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0,  0));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 27, 91, 1, 1, 0, 0, 1));
    tbl.push_back(v(1, 0, 0, 1, 0, 0, 0, 27, 1, 1, 0, 0,  2));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 30, 1, 1, 0, 0,  3));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 76, 1, 1, 0, 0,  4));
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0,  5, 0, 1, 0, 0,  5));
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0,  5, 0, 1, 0, 0,  5));
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0,  5, 0, 1, 0, 0,  5));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  5, 1, 1, 0, 0,  5));
    tbl.push_back(v(1, 0, 1, 0, 0, 0, 0,  6, 1, 1, 0, 0,  6));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  7, 1, 1, 0, 0,  7));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  8, 1, 1, 0, 0,  8));
    tbl.push_back(v(1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0,  9));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  9));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0,  9));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 91, 1, 1, 0, 0, 10));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 91, 0, 0, 1, 91, 10));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 91, 0, 0, 1, 91, 10));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0,  0));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 27, 91, 1, 1, 0, 0, 1));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 27, 1, 1, 0, 0,  2));
    tbl.push_back(v(1, 0, 0, 1, 0, 0, 0, 30, 1, 1, 0, 0,  3));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 12, 1, 1, 0, 0,  4));
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 12, 0, 0, 1, 12, 4));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 12, 0, 0, 1, 12, 4));
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0,  0));
    tbl.push_back(v(1, 1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0,  0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0,  0));
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 91, 0, 1, 0, 0,  1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 91, 0, 1, 0, 0,  1));
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0,  0));

    rst_n = 0; start = 0; halt_req = 0; alu_z = 0; alu_n = 0;
    disp_addr = 0; disp_valid = 0; mem_wait = 0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n; start = tbl[i].start; halt_req = tbl[i].halt;
      alu_z = tbl[i].z; alu_n = 0; mem_wait = tbl[i].mw;
      disp_valid = tbl[i].dv; disp_addr = 7'(tbl[i].da);
      #1;
      chk($sformatf("vec%0d uaddr", i),     32'(uaddr),     32'(tbl[i].e_ua));
      chk($sformatf("vec%0d uexec", i),     32'(uexec),     32'(tbl[i].e_ux));
      chk($sformatf("vec%0d running", i),   32'(running),   32'(tbl[i].e_run));
      chk($sformatf("vec%0d trap", i),      32'(trap),      32'(tbl[i].e_tr));
      chk($sformatf("vec%0d trap_addr", i), 32'(trap_addr), 32'(tbl[i].e_ta));
      chk($sformatf("vec%0d ucycles", i),   32'(ucycles),   32'(tbl[i].e_ucy));
    end

    // Randomized control store and inputs against the reference model.
    @(negedge clk);
    for (int i = 0; i < 128; i++) begin
      int nx, sl;
      if ($urandom % 8 == 0) nx = 0;
      else if ($urandom % 16 == 0) nx = int'($urandom_range(92, 127));
      else nx = int'($urandom_range(0, 91));
      sl = ($urandom % 4 == 0) ? 3 : int'($urandom % 3);
      rom[i] = mk(nx, sl, 1'($urandom), 1'($urandom));
      rom[i][22:11] = 12'($urandom);
    end
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c > 0) @(negedge clk);
      rst_n      = (c == 0) ? 1'b0 : ($urandom % 80 != 0);
      start      = ($urandom % 3 == 0);
      halt_req   = ($urandom % 12 == 0);
      mem_wait   = ($urandom % 4 == 0);
      alu_z      = 1'($urandom);
      alu_n      = 1'($urandom);
      disp_valid = ($urandom % 12 != 0);
      disp_addr  = ($urandom % 10 == 0) ? 7'($urandom_range(92, 127)) : 7'($urandom_range(0, 91));
      #1;
      chk("rnd uaddr",     32'(uaddr),     32'(m_mpc));
      chk("rnd uexec",     32'(uexec),     32'(m_st == M_RUN && !mem_wait));
      chk("rnd running",   32'(running),   32'(m_st == M_RUN));
      chk("rnd trap",      32'(trap),      32'(m_trap));
      chk("rnd trap_addr", 32'(trap_addr), 32'(m_taddr));
      chk("rnd ucycles",   32'(ucycles),   32'(m_ucy));
      model_step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
